vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator; successor to the fixed 640x480 sync generator. Adds:
- per-axis configurable timing and counter width
- sync polarity control
- pixel clock-enable (runs from a fast system clock)
- single-cycle line/frame end strobes
- output registering so hsync/vsync/display_on are cycle-aligned with hpos/vpos

Sits between the clock/reset top level and the pixel renderers (game-of-life cell fetch, RGB mux).

---
 rtl/vga_timing_pkg.sv | 40 ++++
 rtl/vga_axis_counter.sv | 66 ++++++
 rtl/vga_timing_gen.sv | 104 ++++++++++
 tb/tb_vga_timing_gen.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 and 800x600@60) and a helper that
// derives an axis's total length and sync-window bounds from its four segments.
package vga_timing_pkg;

  localparam int unsigned VGA640_H_DISPLAY = 640;
  localparam int unsigned VGA640_H_FRONT   = 16;
  localparam int unsigned VGA640_H_SYNC    = 96;
  localparam int unsigned VGA640_H_BACK    = 48;
  localparam int unsigned VGA640_V_DISPLAY = 480;
  localparam int unsigned VGA640_V_BOTTOM  = 10;
  localparam int unsigned VGA640_V_SYNC    = 2;
  localparam int unsigned VGA640_V_TOP     = 33;

  localparam int unsigned SVGA800_H_DISPLAY = 800;
  localparam int unsigned SVGA800_H_FRONT   = 40;
  localparam int unsigned SVGA800_H_SYNC    = 128;
  localparam int unsigned SVGA800_H_BACK    = 88;
  localparam int unsigned SVGA800_V_DISPLAY = 600;
  localparam int unsigned SVGA800_V_BOTTOM  = 1;
  localparam int unsigned SVGA800_V_SYNC    = 4;
  localparam int unsigned SVGA800_V_TOP     = 23;

  typedef struct packed {
    logic [31:0] total;
    logic [31:0] sync_start;
    logic [31:0] sync_last;
  } axis_bounds_t;

  function automatic axis_bounds_t axis_bounds(input int unsigned display,
                                               input int unsigned front,
                                               input int unsigned sync,
                                               input int unsigned back);
    axis_bounds_t b;
    b.total      = display + front + sync + back;
    b.sync_start = display + front;
    b.sync_last  = display + front + sync - 1;
    return b;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap strobe, plus sync and visible
// flags registered from the next position so they align with o_pos.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned DISPLAY     = 640,
  parameter int unsigned FRONT       = 16,
  parameter int unsigned SYNC        = 96,
  parameter int unsigned BACK        = 48,
  parameter bit          ACTIVE_HIGH = 1'b1,
  parameter int unsigned CW          = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_inc,
  output logic          o_wrap,
  output logic [CW-1:0] o_pos,
  output logic          o_sync,
  output logic          o_visible
);

  localparam axis_bounds_t B = axis_bounds(DISPLAY, FRONT, SYNC, BACK);
  localparam logic [CW-1:0] LAST       = CW'(B.total - 32'd1);
  localparam logic [CW-1:0] SYNC_START = CW'(B.sync_start);
  localparam logic [CW-1:0] SYNC_LAST  = CW'(B.sync_last);
  localparam logic [CW-1:0] DISP_LAST  = CW'(DISPLAY - 1);

  if (64'(B.total) > (64'd1 << CW)) begin : g_cw_check
    $error("vga_axis_counter: total %0d does not fit in CW=%0d bits", B.total, CW);
  end

  logic [CW-1:0] r_pos;
  logic          r_sync;
  logic          r_visible;
  logic [CW-1:0] w_next_pos;
  logic          w_at_last;
  logic          w_in_sync;

  assign w_at_last = (r_pos == LAST);
  assign o_wrap    = i_inc && !reset && w_at_last;

  always_comb begin
    w_next_pos = r_pos;
    if (i_inc) begin
      w_next_pos = w_at_last ? '0 : r_pos + CW'(1);
    end
    w_in_sync = (w_next_pos >= SYNC_START) && (w_next_pos <= SYNC_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pos     <= '0;
      r_sync    <= !ACTIVE_HIGH;
      r_visible <= 1'b1;
    end else begin
      r_pos     <= w_next_pos;
      r_sync    <= ACTIVE_HIGH ? w_in_sync : !w_in_sync;
      r_visible <= (w_next_pos <= DISP_LAST);
    end
  end

  assign o_pos     = r_pos;
  assign o_sync    = r_sync;
  assign o_visible = r_visible;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel clock-enable.
// Optional VGA_TIMING_PREFETCH_EN adds next_hpos/next_vpos/next_display_on.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY         = VGA640_H_DISPLAY,
  parameter int unsigned H_FRONT           = VGA640_H_FRONT,
  parameter int unsigned H_SYNC            = VGA640_H_SYNC,
  parameter int unsigned H_BACK            = VGA640_H_BACK,
  parameter int unsigned V_DISPLAY         = VGA640_V_DISPLAY,
  parameter int unsigned V_BOTTOM          = VGA640_V_BOTTOM,
  parameter int unsigned V_SYNC            = VGA640_V_SYNC,
  parameter int unsigned V_TOP             = VGA640_V_TOP,
  parameter bit          HSYNC_ACTIVE_HIGH = 1'b1,
  parameter bit          VSYNC_ACTIVE_HIGH = 1'b1,
  parameter int unsigned CW                = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          display_on,
  output logic [CW-1:0] hpos,
  output logic [CW-1:0] vpos,
  output logic          line_end,
  output logic          frame_end
`ifdef VGA_TIMING_PREFETCH_EN
  ,
  output logic [CW-1:0] next_hpos,
  output logic [CW-1:0] next_vpos,
  output logic          next_display_on
`endif
);

  logic w_line_end;
  logic w_frame_end;
  logic w_h_visible;
  logic w_v_visible;

  vga_axis_counter #(
    .DISPLAY    (H_DISPLAY),
    .FRONT      (H_FRONT),
    .SYNC       (H_SYNC),
    .BACK       (H_BACK),
    .ACTIVE_HIGH(HSYNC_ACTIVE_HIGH),
    .CW         (CW)
  ) u_h_axis (
    .clk      (clk),
    .reset    (reset),
    .i_inc    (pix_en),
    .o_wrap   (w_line_end),
    .o_pos    (hpos),
    .o_sync   (hsync),
    .o_visible(w_h_visible)
  );

  // The vertical axis steps once per consumed line, so its wrap is the frame end.
  vga_axis_counter #(
    .DISPLAY    (V_DISPLAY),
    .FRONT      (V_BOTTOM),
    .SYNC       (V_SYNC),
    .BACK       (V_TOP),
    .ACTIVE_HIGH(VSYNC_ACTIVE_HIGH),
    .CW         (CW)
  ) u_v_axis (
    .clk      (clk),
    .reset    (reset),
    .i_inc    (w_line_end),
    .o_wrap   (w_frame_end),
    .o_pos    (vpos),
    .o_sync   (vsync),
    .o_visible(w_v_visible)
  );

  assign display_on = w_h_visible && w_v_visible;
  assign line_end   = w_line_end;
  assign frame_end  = w_frame_end;

`ifdef VGA_TIMING_PREFETCH_EN
  localparam axis_bounds_t HB = axis_bounds(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam axis_bounds_t VB = axis_bounds(V_DISPLAY, V_BOTTOM, V_SYNC, V_TOP);
  localparam logic [CW-1:0] H_LAST      = CW'(HB.total - 32'd1);
  localparam logic [CW-1:0] V_LAST      = CW'(VB.total - 32'd1);
  localparam logic [CW-1:0] H_DISP_LAST = CW'(H_DISPLAY - 1);
  localparam logic [CW-1:0] V_DISP_LAST = CW'(V_DISPLAY - 1);

  logic w_h_last;
  logic w_v_last;

  // Position after the next enabled pixel, independent of the current pix_en.
  always_comb begin
    w_h_last        = (hpos == H_LAST);
    w_v_last        = (vpos == V_LAST);
    next_hpos       = w_h_last ? '0 : hpos + CW'(1);
    next_vpos       = vpos;
    if (w_h_last) begin
      next_vpos = w_v_last ? '0 : vpos + CW'(1);
    end
    next_display_on = (next_hpos <= H_DISP_LAST) && (next_vpos <= V_DISP_LAST);
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised scoreboard bench: a default 640x480 instance and a tiny active-low
// instance share stimulus; expectations come from a pixel-index model.
module tb_vga_timing_gen;

  localparam int unsigned AHD = 640, AHF = 16, AHS = 96, AHB = 48;
  localparam int unsigned AVD = 480, AVF = 10, AVS = 2, AVB = 33;
  localparam int unsigned AHT = AHD + AHF + AHS + AHB;
  localparam int unsigned BHD = 10, BHF = 2, BHS = 3, BHB = 4;
  localparam int unsigned BVD = 6, BVF = 1, BVS = 2, BVB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;

  logic       a_hsync, a_vsync, a_de, a_le, a_fe;
  logic [9:0] a_hpos, a_vpos, a_nh, a_nv;
  logic       a_nde;
  logic       b_hsync, b_vsync, b_de, b_le, b_fe;
  logic [4:0] b_hpos, b_vpos, b_nh, b_nv;
  logic       b_nde;

  always #5 clk = ~clk;

  vga_timing_gen u_dut_a (
    .clk(clk), .reset(rst), .pix_en(pix_en),
    .hsync(a_hsync), .vsync(a_vsync), .display_on(a_de),
    .hpos(a_hpos), .vpos(a_vpos), .line_end(a_le), .frame_end(a_fe)
`ifdef VGA_TIMING_PREFETCH_EN
    , .next_hpos(a_nh), .next_vpos(a_nv), .next_display_on(a_nde)
`endif
  );

  vga_timing_gen #(
    .H_DISPLAY(BHD), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
    .V_DISPLAY(BVD), .V_BOTTOM(BVF), .V_SYNC(BVS), .V_TOP(BVB),
    .HSYNC_ACTIVE_HIGH(1'b0), .VSYNC_ACTIVE_HIGH(1'b0), .CW(5)
  ) u_dut_b (
    .clk(clk), .reset(rst), .pix_en(pix_en),
    .hsync(b_hsync), .vsync(b_vsync), .display_on(b_de),
    .hpos(b_hpos), .vpos(b_vpos), .line_end(b_le), .frame_end(b_fe)
`ifdef VGA_TIMING_PREFETCH_EN
    , .next_hpos(b_nh), .next_vpos(b_nv), .next_display_on(b_nde)
`endif
  );

`ifndef VGA_TIMING_PREFETCH_EN
  assign a_nh = '0; assign a_nv = '0; assign a_nde = 1'b0;
  assign b_nh = '0; assign b_nv = '0; assign b_nde = 1'b0;
`endif

  typedef struct packed {
    int unsigned h, v;
    bit hs, vs, de, le, fe;
    int unsigned nh, nv;
    bit nde;
  } exp_t;

  exp_t qa[$], qb[$];
  exp_t ea, eb;
  longint unsigned na = 0, nb = 0;
  int checks = 0, failures = 0;
  int le_exp_a = 0, le_seen_a = 0, fe_exp_b = 0, fe_seen_b = 0;

  // n = enabled pixels consumed since reset; everything follows from it.
  function automatic exp_t model(input longint unsigned n,
                                 input int unsigned hd, hf, hs, hb,
                                 input int unsigned vd, vf, vs, vb,
                                 input bit hah, vah, r, p);
    exp_t e;
    longint unsigned ht, vt, n1;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    e.h  = int'(n % ht);
    e.v  = int'((n / ht) % vt);
    e.hs = ((e.h >= hd + hf) && (e.h < hd + hf + hs)) == hah;
    e.vs = ((e.v >= vd + vf) && (e.v < vd + vf + vs)) == vah;
    e.de = (e.h < hd) && (e.v < vd);
    e.le = !r && p && (e.h == ht - 1);
    e.fe = e.le && (e.v == vt - 1);
    n1    = n + 1;
    e.nh  = int'(n1 % ht);
    e.nv  = int'((n1 / ht) % vt);
    e.nde = (e.nh < hd) && (e.nv < vd);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit p);
    exp_t e;
    @(negedge clk);
    rst    = r;
    pix_en = p;
    if (r) begin na = 0; nb = 0; end
    else if (p) begin na++; nb++; end
    e = model(na, AHD, AHF, AHS, AHB, AVD, AVF, AVS, AVB, 1'b1, 1'b1, r, p);
    qa.push_back(e);
    le_exp_a += int'(e.le);
    e = model(nb, BHD, BHF, BHS, BHB, BVD, BVF, BVS, BVB, 1'b0, 1'b0, r, p);
    qb.push_back(e);
    fe_exp_b += int'(e.fe);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() != 0) begin
        ea = qa.pop_front();
        check("a_hpos", 32'(a_hpos), ea.h);
        check("a_vpos", 32'(a_vpos), ea.v);
        check("a_hsync", 32'(a_hsync), 32'(ea.hs));
        check("a_vsync", 32'(a_vsync), 32'(ea.vs));
        check("a_display_on", 32'(a_de), 32'(ea.de));
        check("a_line_end", 32'(a_le), 32'(ea.le));
        check("a_frame_end", 32'(a_fe), 32'(ea.fe));
        le_seen_a += int'(a_le === 1'b1);
`ifdef VGA_TIMING_PREFETCH_EN
        check("a_next_hpos", 32'(a_nh), ea.nh);
        check("a_next_vpos", 32'(a_nv), ea.nv);
        check("a_next_display_on", 32'(a_nde), 32'(ea.nde));
`endif
      end
      if (qb.size() != 0) begin
        eb = qb.pop_front();
        check("b_hpos", 32'(b_hpos), eb.h);
        check("b_vpos", 32'(b_vpos), eb.v);
        check("b_hsync", 32'(b_hsync), 32'(eb.hs));
        check("b_vsync", 32'(b_vsync), 32'(eb.vs));
        check("b_display_on", 32'(b_de), 32'(eb.de));
        check("b_line_end", 32'(b_le), 32'(eb.le));
        check("b_frame_end", 32'(b_fe), 32'(eb.fe));
        fe_seen_b += int'(b_fe === 1'b1);
`ifdef VGA_TIMING_PREFETCH_EN
        check("b_next_hpos", 32'(b_nh), eb.nh);
        check("b_next_vpos", 32'(b_nv), eb.nv);
        check("b_next_display_on", 32'(b_nde), 32'(eb.nde));
`endif
      end
    end
  end

  initial begin
    repeat (3) step(1'b1, 1'b0);
    repeat (1700) step(1'b0, 1'b1);
    for (int i = 0; i < 2000; i++) step(1'b0, i[0] == 1'b0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0);
    for (int i = 0; i < 2 * AHT && (na % AHT) != 300; i++) step(1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b1);
    for (int i = 0; i < 3000; i++) step(1'b0, $urandom_range(0, 2) != 0);
    repeat (2) step(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("queue_a_drained", 32'(qa.size()), 32'd0);
    check("queue_b_drained", 32'(qb.size()), 32'd0);
    check("a_line_end_count", 32'(le_seen_a), 32'(le_exp_a));
    check("b_frame_end_count", 32'(fe_seen_b), 32'(fe_exp_b));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
